// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the PC sequencer. Holds the default core
// geometry, the reset and trap PCs, and the sequencer state encoding.
package pc_sequencer_pkg;

  localparam int unsigned DEF_BIN_DIG     = 32;
  localparam int unsigned DEF_CNT_W       = 32;
  localparam int unsigned DEF_MEM_SIZE    = 256;
  localparam logic [31:0] DEF_RESET_PC    = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VECTOR = 32'h0000_0100;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } pc_state_t;

endpackage

// File: rtl/pc_sequencer.sv
// PC sequencer: owns the architectural PC and presents it to fetch as
// fixed_pc_reg. Each cycle the PC holds, advances by 4, or is redirected
// from writeback (misaligned targets go to TRAP_VECTOR with a trap pulse).
// Every redirect raises a one-cycle flush toward decode. fetch_count counts
// sequential advances only.
//
// Build option: define PC_BOUND_CHECK_EN to replace any new PC at or beyond
// MEM_SIZE*4 bytes with TRAP_VECTOR (trap and flush pulse as for a
// misaligned redirect). Without it the PC wraps freely modulo 2^BIN_DIG.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned        BIN_DIG     = DEF_BIN_DIG,
  parameter logic [BIN_DIG-1:0] RESET_PC    = BIN_DIG'(DEF_RESET_PC),
  parameter logic [BIN_DIG-1:0] TRAP_VECTOR = BIN_DIG'(DEF_TRAP_VECTOR),
  parameter int unsigned        CNT_W       = DEF_CNT_W,
  parameter int unsigned        MEM_SIZE    = DEF_MEM_SIZE
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [BIN_DIG-1:0] redirect_target,
  input  logic               halt_req,
  input  logic               resume,
  output logic [BIN_DIG-1:0] fixed_pc_reg,
  output logic               flush,
  output logic               trap,
  output logic               halted,
  output logic [CNT_W-1:0]   fetch_count
);

`ifdef PC_BOUND_CHECK_EN
  localparam bit BOUND_CHECK = 1'b1;
`else
  localparam bit BOUND_CHECK = 1'b0;
`endif

  // First byte address past the end of instruction memory.
  localparam logic [BIN_DIG:0] PC_LIMIT = (BIN_DIG + 1)'(MEM_SIZE) << 2;

  // Sequential successor; plain modular add so the top of the space wraps to 0.
  function automatic logic [BIN_DIG-1:0] pc_incr(input logic [BIN_DIG-1:0] pc);
    return pc + BIN_DIG'(4);
  endfunction

  // Instruction addresses must be word aligned.
  function automatic logic misaligned(input logic [1:0] pc_lsb);
    return |pc_lsb;
  endfunction

  // Folds to constant 0 when the bound check is compiled out.
  function automatic logic out_of_range(input logic [BIN_DIG-1:0] pc);
    return BOUND_CHECK && ({1'b0, pc} >= PC_LIMIT);
  endfunction

  pc_state_t          state_p0, state_p1;
  logic [BIN_DIG-1:0] pc_p0, pc_p1;
  logic               flush_p0, flush_p1;
  logic               trap_p0, trap_p1;
  logic [CNT_W-1:0]   cnt_p0, cnt_p1;
  logic [BIN_DIG-1:0] seq_pc;

  assign seq_pc = pc_incr(pc_p1);

  // Stage 0: next-state / next-PC selection (halt > redirect > stall > sequential).
  always_comb begin
    state_p0 = state_p1;
    pc_p0    = pc_p1;
    flush_p0 = 1'b0;
    trap_p0  = 1'b0;
    cnt_p0   = cnt_p1;
    case (state_p1)
      BOOT: begin
        // One settling cycle for the instruction memory read at RESET_PC.
        state_p0 = RUN;
      end
      RUN: begin
        if (halt_req) begin
          state_p0 = HALTED;
        end
        // A redirect arriving with a halt still lands before the PC freezes.
        if (redirect_valid) begin
          flush_p0 = 1'b1;
          if (misaligned(redirect_target[1:0]) || out_of_range(redirect_target)) begin
            pc_p0   = TRAP_VECTOR;
            trap_p0 = 1'b1;
          end else begin
            pc_p0 = redirect_target;
          end
        end else if (!halt_req && !stall) begin
          cnt_p0 = cnt_p1 + CNT_W'(1);
          if (out_of_range(seq_pc)) begin
            pc_p0    = TRAP_VECTOR;
            trap_p0  = 1'b1;
            flush_p0 = 1'b1;
          end else begin
            pc_p0 = seq_pc;
          end
        end
      end
      HALTED: begin
        // Redirects are ignored here; a fresh halt request beats resume.
        if (resume && !halt_req) begin
          state_p0 = RUN;
        end
      end
      default: begin
        state_p0 = BOOT;
      end
    endcase
  end

  // Stage 1: architectural PC, state, one-cycle pulses and fetch counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p1 <= BOOT;
      pc_p1    <= RESET_PC;
      flush_p1 <= 1'b0;
      trap_p1  <= 1'b0;
      cnt_p1   <= '0;
    end else begin
      state_p1 <= state_p0;
      pc_p1    <= pc_p0;
      flush_p1 <= flush_p0;
      trap_p1  <= trap_p0;
      cnt_p1   <= cnt_p0;
    end
  end

  assign fixed_pc_reg = pc_p1;
  assign flush        = flush_p1;
  assign trap         = trap_p1;
  assign halted       = (state_p1 == HALTED);
  assign fetch_count  = cnt_p1;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed scoreboard bench for pc_sequencer (default build).
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'h0;
  logic        halt_req = 1'b0;
  logic        resume = 1'b0;
  logic [31:0] fixed_pc_reg;
  logic        flush;
  logic        trap;
  logic        halted;
  logic [31:0] fetch_count;

  pc_sequencer dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .halt_req        (halt_req),
    .resume          (resume),
    .fixed_pc_reg    (fixed_pc_reg),
    .flush           (flush),
    .trap            (trap),
    .halted          (halted),
    .fetch_count     (fetch_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    bit          stall;
    bit          rv;
    logic [31:0] tgt;
    bit          halt;
    bit          res;
    logic [31:0] pc;
    bit          fl;
    bit          tr;
    bit          hd;
    logic [31:0] cnt;
  } vec_t;

  typedef struct {
    int          cyc;   // posedge count at which to compare; -1 = compare now
    int          idx;
    logic [31:0] pc;
    bit          fl;
    bit          tr;
    bit          hd;
    logic [31:0] cnt;
  } exp_t;

  vec_t vq[$];
  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  event imm_ev;

  always @(posedge clk) cyc <= cyc + 1;

  // Inputs applied before an edge, and outputs required after that edge.
  function automatic void v(bit rst, bit stall_i, bit rv, logic [31:0] tgt, bit halt, bit res,
                            logic [31:0] pc, bit fl, bit tr, bit hd, logic [31:0] cnt);
    vec_t x;
    x.rst = rst; x.stall = stall_i; x.rv = rv; x.tgt = tgt; x.halt = halt; x.res = res;
    x.pc = pc; x.fl = fl; x.tr = tr; x.hd = hd; x.cnt = cnt;
    vq.push_back(x);
  endfunction

  task automatic check(input exp_t e);
    checks++;
    if (fixed_pc_reg !== e.pc || flush !== e.fl || trap !== e.tr ||
        halted !== e.hd || fetch_count !== e.cnt) begin
      errors++;
      $display("FAIL vec%0d%s: got pc=%h flush=%b trap=%b halted=%b cnt=%0d, expected pc=%h flush=%b trap=%b halted=%b cnt=%0d",
               e.idx, (e.cyc < 0) ? "_async_reset" : "",
               fixed_pc_reg, flush, trap, halted, fetch_count,
               e.pc, e.fl, e.tr, e.hd, e.cnt);
    end
  endtask

  // Monitor: compares outputs against queued expectations at each falling edge
  // (or immediately when an asynchronous event is announced).
  initial begin
    forever begin
      @(negedge clk or imm_ev);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        exp_t e;
        e = sb.pop_front();
        if (e.cyc >= 0 && e.cyc < cyc) begin
          checks++;
          errors++;
          $display("FAIL vec%0d missed: sampled at cycle %0d, required cycle %0d", e.idx, cyc, e.cyc);
        end else begin
          check(e);
        end
      end
    end
  end

  // Driver: applies each vector after a falling edge and queues its expectation.
  initial begin
    //  rst st rv tgt            hl rs   pc             fl tr hd cnt
    v(0, 0, 0, 32'h0,         0, 0,  32'h0,         0, 0, 0, 0);   // 0 held in reset
    v(1, 0, 0, 32'h0,         0, 0,  32'h0,         0, 0, 0, 0);   // 1 BOOT -> RUN
    v(1, 0, 0, 32'h0,         0, 0,  32'h4,         0, 0, 0, 1);   // 2
    v(1, 0, 0, 32'h0,         0, 0,  32'h8,         0, 0, 0, 2);   // 3
    v(1, 0, 0, 32'h0,         0, 0,  32'hC,         0, 0, 0, 3);   // 4
    v(1, 0, 0, 32'h0,         0, 0,  32'h10,        0, 0, 0, 4);   // 5
    v(1, 1, 0, 32'h0,         0, 0,  32'h10,        0, 0, 0, 4);   // 6 stall
    v(1, 1, 0, 32'h0,         0, 0,  32'h10,        0, 0, 0, 4);   // 7 stall
    v(1, 1, 0, 32'h0,         0, 0,  32'h10,        0, 0, 0, 4);   // 8 stall
    v(1, 0, 0, 32'h0,         0, 0,  32'h14,        0, 0, 0, 5);   // 9 release
    v(1, 1, 1, 32'h40,        0, 0,  32'h40,        1, 0, 0, 5);   // 10 redirect beats stall
    v(1, 0, 0, 32'h0,         0, 0,  32'h44,        0, 0, 0, 6);   // 11 flush drops
    v(1, 0, 1, 32'h42,        0, 0,  32'h100,       1, 1, 0, 6);   // 12 misaligned -> trap
    v(1, 0, 0, 32'h0,         0, 0,  32'h104,       0, 0, 0, 7);   // 13 trap drops
    v(1, 0, 1, 32'h1C,        0, 0,  32'h1C,        1, 0, 0, 7);   // 14
    v(1, 0, 0, 32'h0,         0, 0,  32'h20,        0, 0, 0, 8);   // 15
    v(1, 0, 0, 32'h0,         1, 0,  32'h20,        0, 0, 1, 8);   // 16 halt
    v(1, 0, 1, 32'h80,        0, 0,  32'h20,        0, 0, 1, 8);   // 17 redirect ignored
    v(1, 1, 0, 32'h0,         0, 0,  32'h20,        0, 0, 1, 8);   // 18
    v(1, 0, 0, 32'h0,         1, 1,  32'h20,        0, 0, 1, 8);   // 19 halt+resume: stay
    v(1, 0, 0, 32'h0,         0, 0,  32'h20,        0, 0, 1, 8);   // 20
    v(1, 0, 0, 32'h0,         0, 1,  32'h20,        0, 0, 0, 8);   // 21 resume, PC unchanged
    v(1, 0, 0, 32'h0,         0, 0,  32'h24,        0, 0, 0, 9);   // 22
    v(1, 0, 1, 32'h200,       1, 0,  32'h200,       1, 0, 1, 9);   // 23 halt with redirect
    v(1, 0, 0, 32'h0,         0, 1,  32'h200,       0, 0, 0, 9);   // 24
    v(1, 0, 1, 32'h202,       1, 0,  32'h100,       1, 1, 1, 9);   // 25 halt with bad redirect
    v(1, 0, 0, 32'h0,         0, 1,  32'h100,       0, 0, 0, 9);   // 26
    v(1, 0, 1, 32'hFFFF_FFF8, 0, 0,  32'hFFFF_FFF8, 1, 0, 0, 9);   // 27
    v(1, 0, 0, 32'h0,         0, 0,  32'hFFFF_FFFC, 0, 0, 0, 10);  // 28
    v(1, 0, 0, 32'h0,         0, 0,  32'h0,         0, 0, 0, 11);  // 29 wrap
    v(1, 0, 1, 32'h80,        0, 0,  32'h80,        1, 0, 0, 11);  // 30 flush pending
    v(0, 0, 1, 32'hC0,        0, 0,  32'h0,         0, 0, 0, 0);   // 31 reset mid-redirect
    v(1, 0, 0, 32'h0,         0, 0,  32'h0,         0, 0, 0, 0);   // 32 BOOT, no flush
    v(1, 0, 0, 32'h0,         0, 0,  32'h4,         0, 0, 0, 1);   // 33
    v(1, 0, 0, 32'h0,         0, 0,  32'h8,         0, 0, 0, 2);   // 34

    @(negedge clk);
    #2;
    foreach (vq[i]) begin
      exp_t e;
      rst_n           = vq[i].rst;
      stall           = vq[i].stall;
      redirect_valid  = vq[i].rv;
      redirect_target = vq[i].tgt;
      halt_req        = vq[i].halt;
      resume          = vq[i].res;
      e.idx = i; e.pc = vq[i].pc; e.fl = vq[i].fl; e.tr = vq[i].tr;
      e.hd = vq[i].hd; e.cnt = vq[i].cnt;
      if (!vq[i].rst) begin
        #1;
        e.cyc = -1;
        sb.push_back(e);
        ->imm_ev;
      end
      e.cyc = cyc + 1;
      sb.push_back(e);
      @(negedge clk);
      #2;
    end
    stall = 1'b0; redirect_valid = 1'b0; halt_req = 1'b0; resume = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL vec%0d never_compared: got none, required a comparison at cycle %0d", e.idx, e.cyc);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion by %0t, required completion", $time);
    $fatal(1, "timeout");
  end

endmodule
